// File: rtl/spi_master_lockgated.sv
// rtl/spi_master_lockgated.sv - lock-gated byte-oriented SPI master (mode 0)
// Purpose: shifts BYTE_W-bit words out on MOSI (MSB first) while sampling MISO,
//          with SCK = clk_100mhz / (2*CLK_DIV). Transfers only start while the
//          synchronized PLL lock is high; losing lock aborts a transfer in flight.
// Ports:
//   clk_100mhz, rst_n       : PLL output clock, asynchronous active-low reset
//   pll_lock                : raw PLL lock flag (synchronized internally)
//   tx_data/tx_valid/tx_ready, hold_cs : byte request interface
//   rx_data/rx_valid        : received byte, one-cycle completion pulse
//   busy                    : any state other than IDLE
//   spi_sck/spi_mosi/spi_miso/spi_cs_n : SPI pads (all outputs registered)
module spi_master_lockgated #(
    parameter int BYTE_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              hold_cs,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_n
);
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * BYTE_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(2 * BYTE_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              lock_meta_q, lock_meta_d;
    logic              lock_s_q, lock_s_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [BYTE_W-1:0] tx_sh_q, tx_sh_d;
    logic [BYTE_W-1:0] rx_sh_q, rx_sh_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              hold_q, hold_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;

    logic accept;
    logic wrap;
    logic abort;

    assign tx_ready = (state_q == ST_IDLE) && lock_s_q;
    assign accept   = tx_valid && tx_ready;
    assign wrap     = (cnt_q == CNT_MAX);
    // GAP is excluded so a lock that stays low cannot keep restarting the deselect time.
    assign abort    = !lock_s_q && (state_q != ST_IDLE) && (state_q != ST_GAP);

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

    // State register
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            cnt_q       <= '0;
            half_q      <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            hold_q      <= 1'b0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            hold_q      <= hold_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
        end
    end

    // Next state and phase timers. half_q counts SCK half-periods inside SHIFT:
    // even halves have SCK high, odd halves low; the last (odd) half leads to TRAIL.
    always_comb begin
        state_d = state_q;
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        half_d  = half_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) state_d = ST_LEAD;
            end
            ST_LEAD: begin
                if (wrap) begin
                    state_d = ST_SHIFT;
                    half_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (wrap) begin
                    if (half_q == HALF_MAX) state_d = ST_TRAIL;
                    else                    half_d  = half_q + 1'b1;
                end
            end
            ST_TRAIL: begin
                if (wrap) state_d = hold_q ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (wrap) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_GAP;
            cnt_d   = '0;
        end
    end

    // Datapath and registered pad outputs
    always_comb begin
        lock_meta_d = pll_lock;
        lock_s_d    = lock_meta_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        hold_d      = hold_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_sh_d = tx_data;
                    hold_d  = hold_cs;
                    cs_n_d  = 1'b0;
                    mosi_d  = tx_data[BYTE_W-1];
                end else if (!lock_s_q) begin
                    cs_n_d = 1'b1;
                end
            end
            ST_LEAD: begin
                // First rising edge: the MSB has been on MOSI since the accept.
                if (wrap) begin
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh_q[BYTE_W-2:0], spi_miso};
                end
            end
            ST_SHIFT: begin
                if (wrap) begin
                    if (!half_q[0]) begin
                        // Falling edge: advance to the next MOSI bit.
                        sck_d   = 1'b0;
                        tx_sh_d = {tx_sh_q[BYTE_W-2:0], 1'b0};
                        mosi_d  = tx_sh_q[BYTE_W-2];
                    end else if (half_q != HALF_MAX) begin
                        sck_d   = 1'b1;
                        rx_sh_d = {rx_sh_q[BYTE_W-2:0], spi_miso};
                    end
                end
            end
            ST_TRAIL: begin
                if (wrap) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                    if (!hold_q) cs_n_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (abort) begin
            sck_d      = 1'b0;
            cs_n_d     = 1'b1;
            mosi_d     = 1'b0;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
        end
    end
endmodule
